// File: rtl/reg_file_nrd_pkg.sv
// Shared defaults for the reg_file_nrd register file: default geometry and entry reset value.
// Optional macro REGFILE_BYPASS_EN (used in reg_file_nrd.sv) enables write-through forwarding.
package reg_file_nrd_pkg;
   localparam int RF_WIDTH_DEF = 32;
   localparam int RF_DEPTH_DEF = 8;
   localparam int RF_AW_DEF    = 3;
   localparam bit RF_RESET_VAL = 1'b0;
endpackage

// File: rtl/reg_file_nrd_mux_n_to_1.sv
// Combinational 2**AW-way select of WIDTH-bit words from a flattened input bus.
// One instance per read port; the selected word feeds that port's output register.
module mux_n_to_1
   import reg_file_nrd_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH_DEF,
   parameter int AW    = RF_AW_DEF
) (
   input  logic [(2**AW)*WIDTH-1:0] i_data,
   input  logic [AW-1:0]            i_sel,
   output logic [WIDTH-1:0]         o_data
);
   assign o_data = i_data[i_sel*WIDTH +: WIDTH];
endmodule

// File: rtl/reg_file_nrd.sv
// DEPTH x WIDTH register file: one synchronous write port, two registered read ports, written-valid map.
// Macro REGFILE_BYPASS_EN: when defined, a same-cycle write to the read address is forwarded to the read.
module reg_file_nrd
   import reg_file_nrd_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH_DEF,
   parameter int DEPTH = RF_DEPTH_DEF,
   parameter int AW    = RF_AW_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en_a,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic             rd_en_b,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_vld_a,
   output logic             rd_vld_b,
   output logic [DEPTH-1:0] vld_map
);
   generate
      if (AW != $clog2(DEPTH) || DEPTH < 2) begin : g_bad_geometry
         $error("reg_file_nrd: AW must equal clog2(DEPTH) and DEPTH must be >= 2");
      end
   endgenerate

   logic [WIDTH-1:0]       r_mem [DEPTH];
   logic [DEPTH-1:0]       r_vld_map;
   logic [DEPTH*WIDTH-1:0] w_mem_flat;
   logic [WIDTH-1:0]       w_mux_a, w_mux_b;
   logic [WIDTH-1:0]       w_rd_data_a, w_rd_data_b;
   logic                   w_rd_vld_a, w_rd_vld_b;
   logic [WIDTH-1:0]       r_rd_data_a, r_rd_data_b;
   logic                   r_rd_vld_a, r_rd_vld_b;

   // Per-entry storage and valid bit; reset wins over a same-cycle write.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge clk) begin
         if (reset) begin
            r_mem[g]     <= {WIDTH{RF_RESET_VAL}};
            r_vld_map[g] <= 1'b0;
         end else if (wr_en && wr_addr == AW'(g)) begin
            r_mem[g]     <= wr_data;
            r_vld_map[g] <= 1'b1;
         end
      end
      assign w_mem_flat[g*WIDTH +: WIDTH] = r_mem[g];
   end

   mux_n_to_1 #(.WIDTH(WIDTH), .AW(AW)) u_mux_a (
      .i_data (w_mem_flat),
      .i_sel  (rd_addr_a),
      .o_data (w_mux_a)
   );

   mux_n_to_1 #(.WIDTH(WIDTH), .AW(AW)) u_mux_b (
      .i_data (w_mem_flat),
      .i_sel  (rd_addr_b),
      .o_data (w_mux_b)
   );

`ifdef REGFILE_BYPASS_EN
   logic w_hit_a, w_hit_b;
   assign w_hit_a     = wr_en && (wr_addr == rd_addr_a);
   assign w_hit_b     = wr_en && (wr_addr == rd_addr_b);
   assign w_rd_data_a = w_hit_a ? wr_data : w_mux_a;
   assign w_rd_data_b = w_hit_b ? wr_data : w_mux_b;
   assign w_rd_vld_a  = w_hit_a | r_vld_map[rd_addr_a];
   assign w_rd_vld_b  = w_hit_b | r_vld_map[rd_addr_b];
`else
   // Reads see pre-write contents; a colliding write shows up on the next read.
   assign w_rd_data_a = w_mux_a;
   assign w_rd_data_b = w_mux_b;
   assign w_rd_vld_a  = r_vld_map[rd_addr_a];
   assign w_rd_vld_b  = r_vld_map[rd_addr_b];
`endif

   // Read output registers hold their value while the port is idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data_a <= {WIDTH{RF_RESET_VAL}};
         r_rd_vld_a  <= 1'b0;
      end else if (rd_en_a) begin
         r_rd_data_a <= w_rd_data_a;
         r_rd_vld_a  <= w_rd_vld_a;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data_b <= {WIDTH{RF_RESET_VAL}};
         r_rd_vld_b  <= 1'b0;
      end else if (rd_en_b) begin
         r_rd_data_b <= w_rd_data_b;
         r_rd_vld_b  <= w_rd_vld_b;
      end
   end

   assign rd_data_a = r_rd_data_a;
   assign rd_data_b = r_rd_data_b;
   assign rd_vld_a  = r_rd_vld_a;
   assign rd_vld_b  = r_rd_vld_b;
   assign vld_map   = r_vld_map;
endmodule

// File: tb/tb_reg_file_nrd.sv
// Directed bench for reg_file_nrd: default 32x8 instance plus a 16x4 instance.
// Collision expectations follow whether REGFILE_BYPASS_EN is defined for the build.
module tb_reg_file_nrd;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit x 8 instance
   logic        reset = 1'b0, wr_en = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
   logic [2:0]  wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data_a, rd_data_b;
   logic        rd_vld_a, rd_vld_b;
   logic [7:0]  vld_map;

   // 16-bit x 4 instance
   logic        s_reset = 1'b0, s_wr_en = 1'b0, s_rd_en_a = 1'b0, s_rd_en_b = 1'b0;
   logic [1:0]  s_wr_addr = '0, s_rd_addr_a = '0, s_rd_addr_b = '0;
   logic [15:0] s_wr_data = '0;
   logic [15:0] s_rd_data_a, s_rd_data_b;
   logic        s_rd_vld_a, s_rd_vld_b;
   logic [3:0]  s_vld_map;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] tbl  [8] = '{32'h12345678, 32'h13579bdf, 32'h147ad147, 32'h2468ace1,
                             32'h258be258, 32'h3579bdf1, 32'haabbccdd, 32'hffeeddcc};
   logic [15:0] stbl [4] = '{16'h1234, 16'h1357, 16'h147a, 16'h2468};

   reg_file_nrd dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_vld_a(rd_vld_a), .rd_vld_b(rd_vld_b),
      .vld_map(vld_map)
   );

   reg_file_nrd #(.WIDTH(16), .DEPTH(4), .AW(2)) dut_s (
      .clk(clk), .reset(s_reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
      .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b),
      .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b), .rd_vld_a(s_rd_vld_a), .rd_vld_b(s_rd_vld_b),
      .vld_map(s_vld_map)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] exp_coll;
      logic        exp_vld_new;
`ifdef REGFILE_BYPASS_EN
      exp_coll    = 32'h22222222;
      exp_vld_new = 1'b1;
`else
      exp_coll    = 32'h11111111;
      exp_vld_new = 1'b0;
`endif
      #1;
      // Reset
      reset = 1'b1; tick(); reset = 1'b0;
      check("rst_data_a", rd_data_a, 0);
      check("rst_data_b", rd_data_b, 0);
      check("rst_vld_a", rd_vld_a, 0);
      check("rst_vld_b", rd_vld_b, 0);
      check("rst_vld_map", vld_map, 8'h00);

      // Fill and readback
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i); wr_data = tbl[i]; tick();
      end
      wr_en = 1'b0;
      check("fill_vld_map", vld_map, 8'hff);
      for (int i = 0; i < 8; i++) begin
         rd_en_a = 1'b1; rd_addr_a = 3'(i);
         rd_en_b = 1'b1; rd_addr_b = 3'(7 - i);
         tick();
         check($sformatf("rb_a%0d", i), rd_data_a, tbl[i]);
         check($sformatf("rb_b%0d", i), rd_data_b, tbl[7 - i]);
         check($sformatf("rb_vld%0d", i), {rd_vld_a, rd_vld_b}, 2'b11);
      end

      // Hold for 3 cycles with new addresses presented
      rd_en_a = 1'b0; rd_en_b = 1'b0; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("hold_a", rd_data_a, tbl[7]);
         check("hold_b", rd_data_b, tbl[0]);
      end

      // Both ports on the same address
      rd_en_a = 1'b1; rd_en_b = 1'b1; rd_addr_a = 3'd4; rd_addr_b = 3'd4; tick();
      check("same_a", rd_data_a, tbl[4]);
      check("same_b", rd_data_b, tbl[4]);
      rd_en_a = 1'b0; rd_en_b = 1'b0;

      // Reset with a same-cycle write: write is discarded
      reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 32'hdeadbeef; tick();
      reset = 1'b0; wr_en = 1'b0;
      check("rstpri_vld_map", vld_map, 8'h00);
      check("rstpri_data_a", rd_data_a, 0);
      rd_en_a = 1'b1; rd_addr_a = 3'd6; tick(); rd_en_a = 1'b0;
      check("rstpri_entry6", rd_data_a, 0);
      check("rstpri_vld6", rd_vld_a, 0);

      // Unwritten read after writing only entry 2
      wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hcafef00d; tick(); wr_en = 1'b0;
      rd_en_a = 1'b1; rd_addr_a = 3'd5; rd_en_b = 1'b1; rd_addr_b = 3'd2; tick();
      rd_en_a = 1'b0; rd_en_b = 1'b0;
      check("unwr_data_a", rd_data_a, 0);
      check("unwr_vld_a", rd_vld_a, 0);
      check("wr2_data_b", rd_data_b, 32'hcafef00d);
      check("wr2_vld_b", rd_vld_b, 1);
      check("unwr_vld_map", vld_map, 8'h04);

      // Collision on a written entry
      wr_en = 1'b1; wr_addr = 3'd3; wr_data = 32'h11111111; tick();
      wr_data = 32'h22222222; rd_en_a = 1'b1; rd_addr_a = 3'd3; tick();
      wr_en = 1'b0;
      check("coll_data", rd_data_a, exp_coll);
      check("coll_vld", rd_vld_a, 1);
      tick();
      check("coll_next", rd_data_a, 32'h22222222);

      // Collision on a never-written entry (valid bit forwarding)
      wr_en = 1'b1; wr_addr = 3'd7; wr_data = 32'h77777777; rd_addr_a = 3'd7; tick();
      wr_en = 1'b0; rd_en_a = 1'b0;
      check("coll_new_vld", rd_vld_a, exp_vld_new);
      check("coll_new_map", vld_map, 8'h8c);

      // 16-bit x 4 instance: reset and fill/readback
      s_reset = 1'b1; tick(); s_reset = 1'b0;
      check("s_rst_data", {s_rd_data_a, s_rd_data_b}, 0);
      check("s_rst_vld", {s_rd_vld_a, s_rd_vld_b}, 0);
      check("s_rst_vld_map", s_vld_map, 4'h0);
      for (int i = 0; i < 4; i++) begin
         s_wr_en = 1'b1; s_wr_addr = 2'(i); s_wr_data = stbl[i]; tick();
      end
      s_wr_en = 1'b0;
      check("s_fill_vld_map", s_vld_map, 4'hf);
      for (int i = 0; i < 4; i++) begin
         s_rd_en_a = 1'b1; s_rd_addr_a = 2'(i);
         s_rd_en_b = 1'b1; s_rd_addr_b = 2'(3 - i);
         tick();
         check($sformatf("s_rb_a%0d", i), s_rd_data_a, stbl[i]);
         check($sformatf("s_rb_b%0d", i), s_rd_data_b, stbl[3 - i]);
         check($sformatf("s_rb_vld%0d", i), {s_rd_vld_a, s_rd_vld_b}, 2'b11);
      end
      s_rd_en_a = 1'b0; s_rd_en_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
